// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one imem request at a time, tracks the outstanding
// response and buffers {pc, instruction} pairs toward decode in a small FIFO.
module fetch_ctrl #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0]   RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_SIZE-1:0]    redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [PC_SIZE-1:0]    inst_pc,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_KILL
  } state_t;

  state_t                state;
  logic [PC_SIZE-1:0]    fetch_pc;
  logic [PC_SIZE-1:0]    req_pc;
  logic [PC_SIZE-1:0]    pc_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic has_room;
  logic req_fire;
  logic rsp_push;
  logic pop;

  // Room is judged on the registered count only, so a same-cycle pop never
  // opens a slot for a request.
  assign has_room       = (count < FULL);
  assign imem_req_valid = (state == S_REQ) && has_room && !redirect_valid && !rst;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_push   = (state == S_WAIT) && imem_rsp_valid && !redirect_valid && !rst;
  assign inst_valid = (count != '0) && !rst;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_data  = rst ? '0 : data_mem[head];
  assign inst_pc    = rst ? '0 : pc_mem[head];
  assign busy       = (state != S_REQ) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      // A redirect flushes the buffer; an in-flight fetch is either dropped
      // now (response this cycle) or remembered as KILL until it returns.
      fetch_pc <= redirect_pc;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      if (state == S_REQ) state <= S_REQ;
      else                state <= imem_rsp_valid ? S_REQ : S_KILL;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_SIZE'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
        S_KILL:  if (imem_rsp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      if (rsp_push) tail <= tail + PTR_W'(1);
      if (pop)      head <= head + PTR_W'(1);

      case ({rsp_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates every read,
  // so stale entries are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      pc_mem[tail]   <= req_pc;
      data_mem[tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push hand-computed
// request addresses and {pc, data} pairs; a monitor pops and compares.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  logic [31:0] exp_req_q[$];
  inst_t       exp_inst_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction memory content: upper half fixed, lower half from the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // imem model: responds `lat` cycles after an accepted request; reset clears it.
  initial begin : imem_model
    logic        pend;
    int          cnt;
    logic [31:0] pend_addr;
    pend = 1'b0;
    cnt = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = imem_word(pend_addr);
          pend = 1'b0;
        end
      end
      #2;
      if (rst) pend = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        pend = 1'b1;
        cnt = lat;
        pend_addr = imem_req_addr;
      end
    end
  end

  // Monitor: handshakes seen here happen at the following rising edge.
  initial begin : monitor
    inst_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: addr 0x%08h, none expected", imem_req_addr);
        end else begin
          check("req_addr", imem_req_addr, exp_req_q.pop_front());
        end
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (exp_inst_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: pc 0x%08h data 0x%08h, none expected", inst_pc, inst_data);
        end else begin
          e = exp_inst_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
        end
      end
      if (!rst && imem_rsp_valid && !busy) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_in_req: response 0x%08h with no request outstanding", imem_rsp_data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic push_inst(input logic [31:0] pc, input logic [31:0] data);
    inst_t e;
    e.pc = pc;
    e.data = data;
    exp_inst_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while ((exp_req_q.size() != 0 || exp_inst_q.size() != 0) && b < 60) begin
      @(negedge clk);
      b++;
    end
    #3;
    check({name, "_req_left"}, exp_req_q.size(), 0);
    check({name, "_inst_left"}, exp_inst_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset state, then sequential fetch with a 1-cycle imem.
    do_reset();
    #3;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    lat = 1;
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    push_inst(32'h0, 32'hC0DE_0000);
    push_inst(32'h4, 32'hC0DE_0004);
    push_inst(32'h8, 32'hC0DE_0008);
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    #3;
    check("t1_first_valid", imem_req_valid, 1);
    check("t1_first_busy", busy, 0);
    repeat (5) @(negedge clk);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain("t1");

    // Decode stall fills the buffer; release drains in order, fetch resumes.
    do_reset();
    lat = 1;
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    push_inst(32'h0, 32'hC0DE_0000);
    push_inst(32'h4, 32'hC0DE_0004);
    push_inst(32'h8, 32'hC0DE_0008);
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("t2_full_req_valid", imem_req_valid, 0);
    check("t2_full_inst_valid", inst_valid, 1);
    check("t2_full_pc", inst_pc, 32'h0);
    @(negedge clk);
    #3;
    check("t2_stall_pc", inst_pc, 32'h0);
    check("t2_stall_data", inst_data, 32'hC0DE_0000);
    check("t2_stall_req_valid", imem_req_valid, 0);
    @(negedge clk);
    inst_ready = 1'b1;
    #3;
    check("t2_pop_no_room", imem_req_valid, 0);
    @(negedge clk);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain("t2");

    // imem not ready: request held with a stable address.
    do_reset();
    lat = 1;
    exp_req_q.push_back(32'h0);
    push_inst(32'h0, 32'hC0DE_0000);
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t3_hold_valid", imem_req_valid, 1);
      check("t3_hold_addr", imem_req_addr, 32'h0);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain("t3");

    // Redirect while waiting on a slow response: stale response is killed.
    do_reset();
    lat = 3;
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h100);
    push_inst(32'h100, 32'hC0DE_0100);
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #3;
    check("t4_redir_busy", busy, 1);
    check("t4_redir_req_valid", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("t4_kill_busy", busy, 1);
    check("t4_kill_req_valid", imem_req_valid, 0);
    @(negedge clk);
    #3;
    check("t4_stale_busy", busy, 1);
    check("t4_stale_inst_valid", inst_valid, 0);
    @(negedge clk);
    #3;
    check("t4_after_inst_valid", inst_valid, 0);
    check("t4_after_busy", busy, 0);
    check("t4_after_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain("t4");

    // Redirect together with a response and a pop while one entry is buffered.
    do_reset();
    lat = 1;
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h200);
    push_inst(32'h200, 32'hC0DE_0200);
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3;
    check("t5_one_entry_valid", inst_valid, 1);
    check("t5_one_entry_pc", inst_pc, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
    #3;
    check("t5_redir_busy", busy, 1);
    check("t5_redir_req_valid", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("t5_flushed", inst_valid, 0);
    check("t5_after_busy", busy, 0);
    check("t5_after_req_valid", imem_req_valid, 1);
    check("t5_after_addr", imem_req_addr, 32'h200);
    @(negedge clk);
    imem_req_ready = 1'b0;
    drain("t5");

    // PC wrap at the top of the address space, then reset in the middle of WAIT.
    do_reset();
    lat = 3;
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0);
    push_inst(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #3;
    check("t6_redir_req_valid", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #3;
    check("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("t6_wrap_valid", imem_req_valid, 1);
    check("t6_wrap_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #3;
    check("t6_wait_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("t6_rst_req_valid", imem_req_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_inst_valid", inst_valid, 0);
    check("t6_rst_inst_pc", inst_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("t6_post_busy", busy, 0);
    check("t6_post_req_valid", imem_req_valid, 1);
    check("t6_post_addr", imem_req_addr, 32'h0);
    check("t6_post_inst_valid", inst_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      check("t6_no_stale_inst", inst_valid, 0);
    end
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
